// File: rtl/dp_ram_pkg.sv
// dp_ram_pkg: shared types and helpers for dual_port_ram_ctrl.
// Parity is even per byte: stored bit is the XOR of the byte.
package dp_ram_pkg;

  typedef enum logic [1:0] {
    COLL_NONE,
    COLL_WW,
    COLL_RW
  } coll_t;

  function automatic logic par8(
    input logic [7:0] b
  );
    return ^b;
  endfunction

  function automatic int lanes(
    input int dw
  );
    return dw / 8;
  endfunction

endpackage

// File: rtl/dp_ram_rd_pipe.sv
// dp_ram_rd_pipe: per-port registered read path with valid strobe,
// optional second output stage and parity error flag.
module dp_ram_rd_pipe
  import dp_ram_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int OUT_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_perr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              par_err
);

  logic [DATA_W-1:0] s1_data;
  logic              s1_v;
  logic              s1_perr;

  // data only loads on a read so rdata holds between reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_data <= '0;
      s1_perr <= 1'b0;
    end else begin
      s1_v <= rd_en;
      if (rd_en) begin
        s1_data <= rd_data;
        s1_perr <= rd_perr;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] s2_data;
      logic              s2_v;
      logic              s2_perr;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_v    <= 1'b0;
          s2_data <= '0;
          s2_perr <= 1'b0;
        end else begin
          s2_v <= s1_v;
          if (s1_v) begin
            s2_data <= s1_data;
            s2_perr <= s1_perr;
          end
        end
      end

      assign rdata   = s2_data;
      assign rvalid  = s2_v;
      assign par_err = s2_v & s2_perr;
    end else begin : g_direct
      assign rdata   = s1_data;
      assign rvalid  = s1_v;
      assign par_err = s1_v & s1_perr;
    end
  endgenerate

endmodule

// File: rtl/dual_port_ram_ctrl.sv
// dual_port_ram_ctrl: true dual-port RAM, byte enables, read-first,
// port 0 wins write collisions. Parity option: DP_RAM_PARITY_EN.
module dual_port_ram_ctrl
  import dp_ram_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 6,
  parameter int OUT_REG = 0,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en0,
  input  logic                  we0,
  input  logic [DATA_W/8-1:0]   be0,
  input  logic [ADDR_W-1:0]     addr0,
  input  logic [DATA_W-1:0]     wdata0,
  output logic [DATA_W-1:0]     rdata0,
  output logic                  rvalid0,
  input  logic                  en1,
  input  logic                  we1,
  input  logic [DATA_W/8-1:0]   be1,
  input  logic [ADDR_W-1:0]     addr1,
  input  logic [DATA_W-1:0]     wdata1,
  output logic [DATA_W-1:0]     rdata1,
  output logic                  rvalid1,
  output logic                  coll_pulse,
  output logic [CNT_W-1:0]      coll_cnt,
  output logic                  par_err0,
  output logic                  par_err1
);

  localparam int LANES = lanes(DATA_W);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic wr0, wr1, rd0, rd1;
  logic wa0, wa1, same;
  logic perr0, perr1;
  coll_t coll;

  assign wr0  = en0 & we0;
  assign wr1  = en1 & we1;
  assign rd0  = en0 & ~we0;
  assign rd1  = en1 & ~we1;
  assign wa0  = wr0 & (|be0);
  assign wa1  = wr1 & (|be1);
  assign same = en0 & en1 & (addr0 == addr1);

`ifdef DP_RAM_PARITY_EN
  logic [LANES-1:0] par_mem [DEPTH];
  logic [LANES-1:0] wpar0, wpar1;

  function automatic logic [LANES-1:0] par_vec(
    input logic [DATA_W-1:0] d
  );
    logic [LANES-1:0] p;
    p = '0;
    for (int i = 0; i < LANES; i++)
      p[i] = par8(d[8*i +: 8]);
    return p;
  endfunction

  assign wpar0 = par_vec(wdata0);
  assign wpar1 = par_vec(wdata1);
  assign perr0 = |(par_mem[addr0] ^ par_vec(mem[addr0]));
  assign perr1 = |(par_mem[addr1] ^ par_vec(mem[addr1]));
`else
  assign perr0 = 1'b0;
  assign perr1 = 1'b0;
`endif

  // port 1 first so port 0 overrides on shared lanes
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr1 && be1[i]) begin
        mem[addr1][8*i +: 8] <= wdata1[8*i +: 8];
`ifdef DP_RAM_PARITY_EN
        par_mem[addr1][i] <= wpar1[i];
`endif
      end
    end
    for (int i = 0; i < LANES; i++) begin
      if (wr0 && be0[i]) begin
        mem[addr0][8*i +: 8] <= wdata0[8*i +: 8];
`ifdef DP_RAM_PARITY_EN
        par_mem[addr0][i] <= wpar0[i];
`endif
      end
    end
  end

  always_comb begin
    coll = COLL_NONE;
    unique case (1'b1)
      same & wa0 & wa1:
        coll = COLL_WW;
      same & ((wa0 & rd1) | (rd0 & wa1)):
        coll = COLL_RW;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coll_pulse <= 1'b0;
      coll_cnt   <= '0;
    end else begin
      coll_pulse <= (coll != COLL_NONE);
      if (coll != COLL_NONE && coll_cnt != CNT_MAX)
        coll_cnt <= coll_cnt + CNT_W'(1);
    end
  end

  // array read is combinational, so the pipe captures pre-write data
  dp_ram_rd_pipe #(
    .DATA_W  (DATA_W),
    .OUT_REG (OUT_REG)
  ) u_rd0 (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd0),
    .rd_data (mem[addr0]),
    .rd_perr (perr0),
    .rdata   (rdata0),
    .rvalid  (rvalid0),
    .par_err (par_err0)
  );

  dp_ram_rd_pipe #(
    .DATA_W  (DATA_W),
    .OUT_REG (OUT_REG)
  ) u_rd1 (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd1),
    .rd_data (mem[addr1]),
    .rd_perr (perr1),
    .rdata   (rdata1),
    .rvalid  (rvalid1),
    .par_err (par_err1)
  );

endmodule

// File: tb/tb_dual_port_ram_ctrl.sv
// tb_dual_port_ram_ctrl: table-driven vectors with a read scoreboard
// plus reset, saturation and parity sequences.
module tb_dual_port_ram_ctrl;

  localparam int OREG = 0;
  localparam int LAT  = OREG + 1;
  localparam int CNTW = 3;
  localparam int CMAX = 7;

  logic        clk;
  logic        rst;
  logic        en0, we0, en1, we1;
  logic [3:0]  be0, be1;
  logic [5:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic [31:0] rdata0, rdata1;
  logic        rvalid0, rvalid1;
  logic        coll_pulse;
  logic [CNTW-1:0] coll_cnt;
  logic        par_err0, par_err1;

  dual_port_ram_ctrl #(
    .DATA_W  (32),
    .ADDR_W  (6),
    .OUT_REG (OREG),
    .CNT_W   (CNTW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en0        (en0),
    .we0        (we0),
    .be0        (be0),
    .addr0      (addr0),
    .wdata0     (wdata0),
    .rdata0     (rdata0),
    .rvalid0    (rvalid0),
    .en1        (en1),
    .we1        (we1),
    .be1        (be1),
    .addr1      (addr1),
    .wdata1     (wdata1),
    .rdata1     (rdata1),
    .rvalid1    (rvalid1),
    .coll_pulse (coll_pulse),
    .coll_cnt   (coll_cnt),
    .par_err0   (par_err0),
    .par_err1   (par_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en0, we0;
    logic [3:0]  be0;
    logic [5:0]  a0;
    logic [31:0] d0, x0;
    logic        xp0;
    logic        en1, we1;
    logic [3:0]  be1;
    logic [5:0]  a1;
    logic [31:0] d1, x1;
    logic        xc;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    int          due;
    logic        perr;
  } exp_t;

  exp_t        q [2][$];
  logic [31:0] last [2];
  int          cyc;
  int          cnt_model;
  int          n_chk;
  int          n_pass;
  vec_t        tbl [$];

  function automatic vec_t mk(
    input logic e0, input logic w0, input logic [3:0] b0,
    input logic [5:0] a0, input logic [31:0] d0,
    input logic [31:0] x0,
    input logic e1, input logic w1, input logic [3:0] b1,
    input logic [5:0] a1, input logic [31:0] d1,
    input logic [31:0] x1, input logic xc
  );
    vec_t v;
    v.en0 = e0; v.we0 = w0; v.be0 = b0; v.a0 = a0;
    v.d0 = d0; v.x0 = x0; v.xp0 = 1'b0;
    v.en1 = e1; v.we1 = w1; v.be1 = b1; v.a1 = a1;
    v.d1 = d1; v.x1 = x1; v.xc = xc;
    return v;
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h", nm, act, exp);
  endtask

  task automatic idle();
    en0 = 0; we0 = 0; be0 = 0; addr0 = 0; wdata0 = 0;
    en1 = 0; we1 = 0; be1 = 0; addr1 = 0; wdata1 = 0;
  endtask

  task automatic check_port(
    input int p,
    input logic rv,
    input logic [31:0] rd,
    input logic pe
  );
    exp_t e;
    if (rv) begin
      if (q[p].size() == 0) begin
        chk($sformatf("rvalid%0d_unexpected", p), 32'(rv), 0);
      end else begin
        e = q[p].pop_front();
        chk($sformatf("rdata%0d", p), rd, e.data);
        chk($sformatf("latency%0d", p), cyc, e.due);
        chk($sformatf("par_err%0d", p), 32'(pe), 32'(e.perr));
        last[p] = rd;
      end
    end else begin
      chk($sformatf("hold%0d", p), rd, last[p]);
      chk($sformatf("par_err%0d_idle", p), 32'(pe), 0);
      if (q[p].size() > 0 && q[p][0].due <= cyc) begin
        chk($sformatf("rvalid%0d_missing", p), 32'(rv), 1);
        void'(q[p].pop_front());
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_port(0, rvalid0, rdata0, par_err0);
    check_port(1, rvalid1, rdata1, par_err1);
    chk("coll_cnt", 32'(coll_cnt), 32'(cnt_model));
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    en0 = v.en0; we0 = v.we0; be0 = v.be0;
    addr0 = v.a0; wdata0 = v.d0;
    en1 = v.en1; we1 = v.we1; be1 = v.be1;
    addr1 = v.a1; wdata1 = v.d1;
    if (v.en0 && !v.we0) begin
      e.data = v.x0; e.due = cyc + LAT; e.perr = v.xp0;
      q[0].push_back(e);
    end
    if (v.en1 && !v.we1) begin
      e.data = v.x1; e.due = cyc + LAT; e.perr = 1'b0;
      q[1].push_back(e);
    end
    if (v.xc && cnt_model < CMAX) cnt_model++;
    tick();
    chk("coll_pulse", 32'(coll_pulse), 32'(v.xc));
    idle();
  endtask

  initial begin
    vec_t v;
    n_chk = 0; n_pass = 0; cyc = 0; cnt_model = 0;
    last[0] = '0; last[1] = '0;
    rst = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rvalid0", 32'(rvalid0), 0);
    chk("rst_rvalid1", 32'(rvalid1), 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_coll_pulse", 32'(coll_pulse), 0);
    chk("rst_coll_cnt", 32'(coll_cnt), 0);
    chk("rst_par_err", 32'({par_err0, par_err1}), 0);
    rst = 1'b0;
    tick();

    tbl.push_back(mk(1,1,4'hF,5,32'hDEADBEEF,0, 0,0,0,0,0,0, 0));
    tbl.push_back(mk(0,0,0,0,0,0, 1,0,0,5,0,32'hDEADBEEF, 0));
    tbl.push_back(mk(1,1,4'hF,3,32'h11223344,0, 0,0,0,0,0,0, 0));
    tbl.push_back(mk(1,1,4'h2,3,32'h0000AA00,0, 0,0,0,0,0,0, 0));
    tbl.push_back(mk(1,0,0,3,0,32'h1122AA44, 0,0,0,0,0,0, 0));
    tbl.push_back(mk(1,1,4'h3,7,32'hAAAAAAAA,0,
                     1,1,4'hF,7,32'h55555555,0, 1));
    tbl.push_back(mk(1,0,0,7,0,32'h5555AAAA,
                     1,0,0,7,0,32'h5555AAAA, 0));
    tbl.push_back(mk(1,1,4'hF,9,32'h1,0, 0,0,0,0,0,0, 0));
    tbl.push_back(mk(1,0,0,9,0,32'h1, 1,1,4'hF,9,32'h2,0, 1));
    tbl.push_back(mk(1,0,0,9,0,32'h2, 0,0,0,0,0,0, 0));
    tbl.push_back(mk(1,1,4'h0,9,32'hFFFFFFFF,0,
                     1,0,0,9,0,32'h2, 0));
    tbl.push_back(mk(1,1,4'hF,9,32'h33333333,0,
                     1,0,0,9,0,32'h2, 1));
    tbl.push_back(mk(1,0,0,9,0,32'h33333333,
                     1,0,0,5,0,32'hDEADBEEF, 0));
    tbl.push_back(mk(1,0,0,3,0,32'h1122AA44,
                     1,1,4'hF,63,32'hCAFEF00D,0, 0));
    tbl.push_back(mk(1,1,4'hF,0,32'h0BADF00D,0,
                     1,0,0,63,0,32'hCAFEF00D, 0));
    tbl.push_back(mk(1,0,0,0,0,32'h0BADF00D,
                     1,0,0,0,0,32'h0BADF00D, 0));
    tbl.push_back(mk(1,1,4'hC,1,32'h12340000,0,
                     1,1,4'h3,1,32'h00005678,0, 1));
    tbl.push_back(mk(0,0,0,0,0,0, 1,0,0,1,0,32'h12345678, 0));

    foreach (tbl[i]) apply(tbl[i]);
    repeat (LAT + 1) tick();

    // drive the counter into saturation
    for (int i = 0; i < 6; i++)
      apply(mk(1,1,4'h1,2,32'(i),0, 1,1,4'h2,2,32'(i),0, 1));
    tick();

    // reset with a read in flight
    en0 = 1; we0 = 0; addr0 = 5;
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b1;
    idle();
    @(negedge clk);
    chk("mid_rst_rvalid0", 32'(rvalid0), 0);
    chk("mid_rst_rdata0", rdata0, 0);
    chk("mid_rst_coll_cnt", 32'(coll_cnt), 0);
    chk("mid_rst_coll_pulse", 32'(coll_pulse), 0);
    q[0].delete(); q[1].delete();
    last[0] = '0; last[1] = '0;
    cnt_model = 0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    apply(mk(1,0,0,5,0,32'hDEADBEEF,
             1,0,0,7,0,32'h5555AAAA, 0));
    repeat (LAT + 1) tick();

`ifdef DP_RAM_PARITY_EN
    apply(mk(1,1,4'hF,4,32'h12345678,0, 0,0,0,0,0,0, 0));
    dut.par_mem[4][0] = ~dut.par_mem[4][0];
    v = mk(1,0,0,4,0,32'h12345678, 0,0,0,0,0,0, 0);
    v.xp0 = 1'b1;
    apply(v);
    apply(mk(1,0,0,5,0,32'hDEADBEEF, 0,0,0,0,0,0, 0));
    repeat (LAT + 1) tick();
`else
    v = mk(1,0,0,4,0,0, 0,0,0,0,0,0, 0);
    v.en0 = 1'b0;
    apply(v);
`endif

    chk("q0_drained", 32'(q[0].size()), 0);
    chk("q1_drained", 32'(q[1].size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
